// File: rtl/multicycle_controller.sv
// Central sequencer for the multi-cycle RV32 core: steps each instruction
// through fetch/decode/execute/mem/writeback with timeout, halt and retire count.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_ready,
    output logic                 imem_req,
    output logic                 ir_we,
    input  logic                 dmem_ready,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 compare,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [4:0]           rd_addr,
    input  logic                 branch_taken,
    input  logic                 halt_req,
    output logic                 pc_we,
    output logic                 pc_sel,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 halted,
    output logic                 fault,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_HALTED,
        S_FAULT
    } state_e;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_e               state_q, state_d;
    logic [7:0]           tmo_q, tmo_d;
    logic                 taken_q, taken_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        taken_d   = taken_q;
        instret_d = instret_q;
        unique case (state_q)
            S_FETCH: begin
                if (imem_ready)         state_d = S_DECODE;
                else if (tmo_q == TMO)  state_d = S_FAULT;
                else                    tmo_d   = tmo_q + 8'd1;
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                taken_d = branch & branch_taken;
                state_d = (mem_read | mem_write) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ready)         state_d = S_WB;
                else if (tmo_q == TMO)  state_d = S_FAULT;
                else                    tmo_d   = tmo_q + 8'd1;
            end
            S_WB: begin
                instret_d = instret_q + 1'b1;
                state_d   = halt_req ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                if (!halt_req) state_d = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
        // every state entry starts a fresh wait budget
        if (state_d != state_q) tmo_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            tmo_q     <= '0;
            taken_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            taken_q   <= taken_d;
            instret_q <= instret_d;
        end
    end

    // strobes are masked while rst is sampled so nothing commits on that edge
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 2'd0;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = mem_write;
                end
                S_WB: begin
                    pc_we  = 1'b1;
                    pc_sel = jump | taken_q;
                    rf_we  = (rd_addr != 5'd0) && !branch && !mem_write;
                    if (mem_read)     wb_sel = 2'd1;
                    else if (jump)    wb_sel = 2'd2;
                    else if (compare) wb_sel = 2'd3;
                    else              wb_sel = 2'd0;
                end
                default: ;
            endcase
        end
    end

    assign halted  = (state_q == S_HALTED);
    assign fault   = (state_q == S_FAULT);
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction timeline
// reference model with randomized waits, noise on unowned inputs and faults.
module tb_multicycle_controller;

    localparam int TMO = 4;
    localparam int IW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_ready, imem_req, ir_we;
    logic          dmem_ready, dmem_req, dmem_we;
    logic          branch, jump, compare, mem_read, mem_write;
    logic [4:0]    rd_addr;
    logic          branch_taken, halt_req;
    logic          pc_we, pc_sel, rf_we;
    logic [1:0]    wb_sel;
    logic          halted, fault;
    logic [IW-1:0] instret;
    logic [10:0]   obs;

    int n_cmp   = 0;
    int n_err   = 0;
    int retired = 0;

    typedef struct {
        logic          ir;
        logic          dr;
        logic          ht;
        logic          rs;
        logic [10:0]   dv;
        logic [10:0]   exp;
        logic [IW-1:0] ins;
        string         tag;
    } cyc_t;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(TMO), .INSTRET_W(IW)) dut (
        .clk(clk), .rst(rst),
        .imem_ready(imem_ready), .imem_req(imem_req), .ir_we(ir_we),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .branch(branch), .jump(jump), .compare(compare),
        .mem_read(mem_read), .mem_write(mem_write), .rd_addr(rd_addr),
        .branch_taken(branch_taken), .halt_req(halt_req),
        .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .halted(halted), .fault(fault), .instret(instret)
    );

    assign obs = {imem_req, ir_we, dmem_req, dmem_we, pc_we,
                  pc_sel, rf_we, wb_sel, halted, fault};

    function automatic logic [10:0] mk(
        logic ireq, logic irwe, logic dreq, logic dwe, logic pcwe,
        logic psel, logic rfwe, logic [1:0] wbs, logic hl, logic ft);
        return {ireq, irwe, dreq, dwe, pcwe, psel, rfwe, wbs, hl, ft};
    endfunction

    // Builds the expected cycle-by-cycle timeline of one instruction, then plays it.
    task automatic run_instr(
        string nm, logic br, logic jp, logic cm, logic mr, logic mw,
        logic [4:0] rd, logic bt, int idl, int ddl,
        logic hlt, int hcyc, int rst_mem);
        cyc_t          q[$];
        cyc_t          c;
        logic [IW-1:0] ins;
        logic [1:0]    wbs;
        logic [9:0]    fixed;
        bit            was_reset;
        was_reset = 0;
        ins   = IW'(retired);
        fixed = {br, jp, cm, mr, mw, rd};
        c.rs  = 1'b0;
        c.ins = ins;
        for (int w = 0; w <= idl; w++) begin
            c.ir  = (w == idl);
            c.dr  = 1'($urandom);
            c.ht  = 1'($urandom);
            c.dv  = 11'($urandom);
            c.exp = mk(1'b1, (w == idl), 1'b0, 1'b0, 1'b0,
                       1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
            c.tag = "fetch";
            q.push_back(c);
        end
        for (int s = 0; s < 2; s++) begin
            c.ir  = 1'($urandom);
            c.dr  = 1'($urandom);
            c.ht  = hlt;
            c.dv  = {fixed, (s == 1) ? bt : 1'($urandom)};
            c.exp = '0;
            c.tag = (s == 0) ? "decode" : "execute";
            q.push_back(c);
        end
        if (mr | mw) begin
            for (int w = 0; w <= ddl; w++) begin
                c.ir  = 1'($urandom);
                c.dr  = (w == ddl);
                c.ht  = hlt;
                c.dv  = {fixed, 1'($urandom)};
                c.exp = mk(1'b0, 1'b0, 1'b1, mw, 1'b0,
                           1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
                c.tag = "mem";
                if (w == rst_mem) begin
                    c.rs  = 1'b1;
                    c.exp = '0;
                    c.tag = "rst_mem";
                    was_reset = 1;
                    q.push_back(c);
                    break;
                end
                q.push_back(c);
            end
        end
        if (!was_reset) begin
            wbs = mr ? 2'd1 : jp ? 2'd2 : cm ? 2'd3 : 2'd0;
            c.ir  = 1'($urandom);
            c.dr  = 1'($urandom);
            c.ht  = hlt;
            c.dv  = {fixed, 1'($urandom)};
            c.exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, jp | (br & bt),
                       !(br | mw | (rd == 5'd0)), wbs, 1'b0, 1'b0);
            c.tag = "writeback";
            q.push_back(c);
            if (hlt) begin
                for (int h = 0; h <= hcyc; h++) begin
                    c.ir  = 1'($urandom);
                    c.dr  = 1'($urandom);
                    c.ht  = (h != hcyc);
                    c.dv  = 11'($urandom);
                    c.exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
                    c.ins = IW'(retired + 1);
                    c.tag = "halted";
                    q.push_back(c);
                end
            end
        end
        foreach (q[i]) begin
            rst        = q[i].rs;
            imem_ready = q[i].ir;
            dmem_ready = q[i].dr;
            halt_req   = q[i].ht;
            {branch, jump, compare, mem_read, mem_write,
             rd_addr, branch_taken} = q[i].dv;
            @(negedge clk);
            n_cmp++;
            if ({obs, instret} !== {q[i].exp, q[i].ins}) begin
                n_err++;
                $display("FAIL %s/%s cyc %0d: got obs=%b instret=%0d want obs=%b instret=%0d",
                         nm, q[i].tag, i, obs, instret, q[i].exp, q[i].ins);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        if (was_reset) retired = 0;
        else           retired++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0;
        {branch, jump, compare, mem_read, mem_write, rd_addr, branch_taken} = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (obs !== 11'd0) begin
            n_err++;
            $display("FAIL reset_hold: got %b want %b", obs, 11'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({obs, instret} !== {mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 2'd0, 1'b0, 1'b0), IW'(0)}) begin
            n_err++;
            $display("FAIL reset_state: got %b/%0d want imem_req only/0", obs, instret);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_drop_req: got %b want 0", imem_req);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        retired = 0;
    endtask

    task automatic test_alu;
        run_instr("add_x5", 0, 0, 0, 0, 0, 5'd5, 0, 0, 0, 0, 0, -1);
        run_instr("slt_x7_wait", 0, 0, 1, 0, 0, 5'd7, 1, 2, 0, 0, 0, -1);
    endtask

    task automatic test_mem;
        run_instr("lw_x3", 0, 0, 0, 1, 0, 5'd3, 0, 0, 3, 0, 0, -1);
        run_instr("sw", 0, 0, 0, 0, 1, 5'd9, 0, 1, 0, 0, 0, -1);
        run_instr("lw_edge_tmo", 0, 0, 0, 1, 0, 5'd1, 0, TMO, TMO, 0, 0, -1);
    endtask

    task automatic test_branch_jump;
        run_instr("beq_taken", 1, 0, 0, 0, 0, 5'd4, 1, 0, 0, 0, 0, -1);
        run_instr("beq_not", 1, 0, 0, 0, 0, 5'd4, 0, 0, 0, 0, 0, -1);
        run_instr("jal_x0", 0, 1, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, -1);
        run_instr("jal_x1", 0, 1, 0, 0, 0, 5'd1, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic test_halt;
        run_instr("halt_long", 0, 0, 0, 0, 0, 5'd2, 0, 0, 0, 1, 3, -1);
        run_instr("halt_short", 0, 0, 0, 0, 0, 5'd2, 0, 1, 0, 1, 0, -1);
        run_instr("after_halt", 0, 0, 0, 0, 0, 5'd6, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic test_timeout;
        halt_req = 1'b0;
        for (int w = 0; w <= TMO; w++) begin
            imem_ready = 1'b0;
            dmem_ready = 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if (obs !== mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 2'd0, 1'b0, 1'b0)) begin
                n_err++;
                $display("FAIL tmo_wait%0d: got %b want imem_req only", w, obs);
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom);
            halt_req   = 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({obs, instret} !== {mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b0, 2'd0, 1'b0, 1'b1), IW'(retired)}) begin
                n_err++;
                $display("FAIL fault_hold%0d: got %b/%0d want fault only/%0d",
                         k, obs, instret, retired);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        imem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fault !== 1'b1 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL fault_rst_cycle: got fault=%b req=%b want 1/0", fault, imem_req);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        retired = 0;
        run_instr("post_fault", 0, 0, 0, 0, 0, 5'd8, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic test_wrap;
        int start;
        start = retired;
        for (int i = 0; i < 17; i++)
            run_instr("wrap", 0, 0, 0, 0, 0, 5'(i + 1), 0, 0, 0, 0, 0, -1);
        @(negedge clk);
        n_cmp++;
        if (instret !== IW'(start + 17)) begin
            n_err++;
            $display("FAIL wrap: got %0d want %0d", instret, IW'(start + 17));
        end
        @(posedge clk); #1;
        imem_ready = 1'b0;
    endtask

    task automatic test_rst_mid_mem;
        run_instr("lw_rst", 0, 0, 0, 1, 0, 5'd3, 0, 0, 3, 0, 0, 1);
        run_instr("after_rst", 0, 0, 0, 0, 0, 5'd3, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic test_back_to_back;
        int t;
        logic [4:0] rd;
        for (int i = 0; i < 30; i++) begin
            t  = $urandom_range(0, 5);
            rd = 5'($urandom);
            case (t)
                0: run_instr("rnd_alu", 0, 0, 0, 0, 0, rd, 1'($urandom),
                             $urandom_range(0, TMO), 0,
                             ($urandom_range(0, 7) == 0), $urandom_range(0, 2), -1);
                1: run_instr("rnd_lw", 0, 0, 0, 1, 0, rd, 1'($urandom),
                             $urandom_range(0, TMO), $urandom_range(0, TMO),
                             ($urandom_range(0, 7) == 0), $urandom_range(0, 2), -1);
                2: run_instr("rnd_sw", 0, 0, 0, 0, 1, rd, 1'($urandom),
                             $urandom_range(0, TMO), $urandom_range(0, TMO), 0, 0, -1);
                3: run_instr("rnd_br", 1, 0, 0, 0, 0, rd, 1'($urandom),
                             $urandom_range(0, TMO), 0, 0, 0, -1);
                4: run_instr("rnd_jal", 0, 1, 0, 0, 0, rd, 1'($urandom),
                             $urandom_range(0, TMO), 0,
                             ($urandom_range(0, 7) == 0), $urandom_range(0, 2), -1);
                default: run_instr("rnd_slt", 0, 0, 1, 0, 0, rd, 1'($urandom),
                                   $urandom_range(0, TMO), 0, 0, 0, -1);
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch_jump();
        test_halt();
        test_timeout();
        test_wrap();
        test_rst_mid_mem();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
